chan_msg_arbiter: RTL and testbench

- Shares the single inter-CPU message bus between `N_REQ` channel controllers.
- Each controller emits a one-cycle request pulse carrying a message code, a channel address and data. The arbiter captures each pulse into a per-requester pending slot, grants slots round-robin, drives the shared bus with a valid/ready handshake, and returns a one-cycle done pulse to the winner.
- Sits between the per-core channel controllers and the dispatcher's message port.

---
 rtl/chan_msg_arbiter_pkg.sv | 15 +
 rtl/chan_msg_arbiter_rr_pick.sv | 27 ++
 rtl/chan_msg_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_chan_msg_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chan_msg_arbiter_pkg.sv
// Shared types and helpers for the channel message bus arbiter.
package chan_msg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    // Index increment with wrap at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/chan_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr_i.
module rr_pick
    import chan_msg_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] winner_o
);

    // Walk offsets from farthest to nearest so the nearest pending slot wins.
    always_comb begin
        any_o    = |pend_i;
        winner_o = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((32'(rr_ptr_i) + k - 1) % N_REQ);
            if (pend_i[idx]) begin
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/chan_msg_arbiter.sv
// Round-robin arbiter sharing the inter-CPU message bus between N_REQ channel
// controllers. Optional watchdog on the bus handshake: `CHAN_ARB_TIMEOUT_EN.
module chan_msg_arbiter
    import chan_msg_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ   = 4,
    parameter  int unsigned MSG_W   = 8,
    parameter  int unsigned ADDR_W  = 32,
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned TIMEOUT = 255,
    localparam int unsigned SRC_W   = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_pulse,
    input  logic [N_REQ*MSG_W-1:0]   req_msg,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_done,
    output logic [N_REQ-1:0]         req_ovf,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [MSG_W-1:0]         bus_msg,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_data,
    output logic [SRC_W-1:0]         bus_src,
    output logic                     is_bus_busy,
    output logic                     tmo_err
);

    arb_state_e        state_q;
    logic [N_REQ-1:0]  pend_q, pend_d;
    logic [N_REQ-1:0]  ovf_q, ovf_d;
    logic [N_REQ-1:0]  load_d;
    logic [N_REQ-1:0]  consume;
    logic [N_REQ-1:0]  done_q;
    logic [SRC_W-1:0]  rr_q;
    logic [SRC_W-1:0]  src_q;
    logic              valid_q;
    logic [MSG_W-1:0]  bmsg_q;
    logic [ADDR_W-1:0] baddr_q;
    logic [DATA_W-1:0] bdata_q;

    logic [MSG_W-1:0]  slot_msg_q  [N_REQ];
    logic [ADDR_W-1:0] slot_addr_q [N_REQ];
    logic [DATA_W-1:0] slot_data_q [N_REQ];

    logic              any;
    logic [SRC_W-1:0]  winner;
    logic              grant;
    logic              drive_exit;
    logic              tmo_hit;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .pend_i   (pend_q),
        .rr_ptr_i (rr_q),
        .any_o    (any),
        .winner_o (winner)
    );

    assign grant   = (state_q == ST_IDLE) && any;
    assign consume = grant ? (N_REQ'(1) << winner) : '0;

`ifdef CHAN_ARB_TIMEOUT_EN
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TCNT_W-1:0] tcnt_q;
    logic              tmo_q;

    assign tmo_hit = !bus_ready && (tcnt_q == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else if (state_q != ST_DRIVE) begin
            tcnt_q <= '0;
        end else if (tmo_hit) begin
            tmo_q  <= 1'b1;
        end else if (!bus_ready) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    assign tmo_err = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    assign drive_exit = bus_ready || tmo_hit;

    // A pulse on the grant edge of its own slot refills it instead of overflowing.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        load_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_pulse[i]) begin
                if (!pend_q[i] || consume[i]) begin
                    load_d[i] = 1'b1;
                    pend_d[i] = 1'b1;
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end else if (consume[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_msg_q[i]  <= '0;
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (load_d[i]) begin
                    slot_msg_q[i]  <= req_msg[i*MSG_W +: MSG_W];
                    slot_addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
                    slot_data_q[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            bmsg_q  <= '0;
            baddr_q <= '0;
            bdata_q <= '0;
            src_q   <= '0;
            done_q  <= '0;
            rr_q    <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        bmsg_q  <= slot_msg_q[winner];
                        baddr_q <= slot_addr_q[winner];
                        bdata_q <= slot_data_q[winner];
                        src_q   <= winner;
                        valid_q <= 1'b1;
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (drive_exit) begin
                        valid_q       <= 1'b0;
                        bmsg_q        <= '0;
                        baddr_q       <= '0;
                        bdata_q       <= '0;
                        done_q[src_q] <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rr_q    <= SRC_W'(wrap_inc(32'(src_q), N_REQ));
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_done    = done_q;
    assign req_ovf     = ovf_q;
    assign bus_valid   = valid_q;
    assign bus_msg     = bmsg_q;
    assign bus_addr    = baddr_q;
    assign bus_data    = bdata_q;
    assign bus_src     = src_q;
    assign is_bus_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_chan_msg_arbiter.sv
// Randomized and directed bench for chan_msg_arbiter against a transaction-level model.
module tb_chan_msg_arbiter;

    localparam int N = 4;
    localparam int TMO = 8;
`ifdef CHAN_ARB_TIMEOUT_EN
    localparam int BP_CYC = 6;
`else
    localparam int BP_CYC = 10;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_pulse = '0;
    logic [N*8-1:0]  req_msg = '0;
    logic [N*32-1:0] req_addr = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]  req_done, req_ovf;
    logic          bus_valid, bus_ready = 1'b0;
    logic [7:0]    bus_msg;
    logic [31:0]   bus_addr, bus_data;
    logic [1:0]    bus_src;
    logic          is_bus_busy, tmo_err;

    chan_msg_arbiter #(.N_REQ(N), .MSG_W(8), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_pulse(req_pulse), .req_msg(req_msg),
        .req_addr(req_addr), .req_data(req_data), .req_done(req_done), .req_ovf(req_ovf),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_msg(bus_msg), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_src(bus_src), .is_bus_busy(is_bus_busy), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Model: pending slots, pointer, and a transfer phase (0 free, 1 on bus, 2 completing).
    bit          m_pend [N];
    logic [7:0]  m_msg  [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];
    int          m_rr, m_src, m_phase, m_cnt;
    bit          m_valid, m_tmo;
    logic [7:0]  m_bmsg;
    logic [31:0] m_baddr, m_bdata;
    logic [N-1:0] m_done, m_ovf;

    int  grants[$];
    bit  prev_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_winner();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_rr = 0; m_src = 0; m_phase = 0; m_cnt = 0;
        m_valid = 0; m_tmo = 0;
        m_bmsg = '0; m_baddr = '0; m_bdata = '0;
        m_done = '0; m_ovf = '0;
        prev_valid = 0;
    endtask

    task automatic model_finish();
        m_valid = 0; m_bmsg = '0; m_baddr = '0; m_bdata = '0;
        m_done[m_src] = 1'b1;
        m_phase = 2;
    endtask

    task automatic model_step();
        int w;
        w = (m_phase == 0) ? pick_winner() : -1;
        m_done = '0;
        case (m_phase)
            0: if (w >= 0) begin
                m_bmsg = m_msg[w]; m_baddr = m_addr[w]; m_bdata = m_data[w];
                m_src = w; m_valid = 1; m_phase = 1; m_cnt = 0;
            end
            1: begin
                if (bus_ready) model_finish();
`ifdef CHAN_ARB_TIMEOUT_EN
                else begin
                    m_cnt++;
                    if (m_cnt == TMO) begin
                        model_finish();
                        m_tmo = 1;
                    end
                end
`endif
            end
            default: begin
                m_rr = (m_src + 1) % N;
                m_phase = 0;
            end
        endcase
        for (int i = 0; i < N; i++) begin
            if (req_pulse[i]) begin
                if (!m_pend[i] || w == i) begin
                    m_pend[i] = 1;
                    m_msg[i]  = req_msg[i*8 +: 8];
                    m_addr[i] = req_addr[i*32 +: 32];
                    m_data[i] = req_data[i*32 +: 32];
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end else if (w == i) begin
                m_pend[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("bus_valid", 64'(bus_valid), 64'(m_valid));
        check("bus_msg", 64'(bus_msg), 64'(m_bmsg));
        check("bus_addr", 64'(bus_addr), 64'(m_baddr));
        check("bus_data", 64'(bus_data), 64'(m_bdata));
        check("bus_src", 64'(bus_src), 64'(m_src));
        check("req_done", 64'(req_done), 64'(m_done));
        check("req_ovf", 64'(req_ovf), 64'(m_ovf));
        check("is_bus_busy", 64'(is_bus_busy), 64'(m_phase != 0));
        check("tmo_err", 64'(tmo_err), 64'(m_tmo));
    endtask

    task automatic cyc(input logic [N-1:0] p, input logic rdy);
        req_pulse = p;
        bus_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (bus_valid && !prev_valid) grants.push_back(int'(bus_src));
        prev_valid = bus_valid;
    endtask

    task automatic set_slot(input int i, input logic [7:0] msg, input logic [31:0] a, input logic [31:0] d);
        req_msg[i*8 +: 8]   = msg;
        req_addr[i*32 +: 32] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic rand_slots();
        for (int i = 0; i < N; i++)
            set_slot(i, ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), $urandom, $urandom);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_pulse = '0;
        bus_ready = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        #3;
        do_reset();

        // Single request on requester 2.
        set_slot(2, 8'h21, 32'h40, 32'hDEAD);
        cyc(4'b0100, 1'b1);
        cyc(4'b0000, 1'b1);
        check("single_valid", 64'(bus_valid), 64'd1);
        check("single_src", 64'(bus_src), 64'd2);
        check("single_msg", 64'(bus_msg), 64'h21);
        check("single_data", 64'(bus_data), 64'hDEAD);
        cyc(4'b0000, 1'b1);
        check("single_done", 64'(req_done), 64'b0100);
        cyc(4'b0000, 1'b1);

        // Fairness: everyone pulses at once, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            grants.delete();
            rand_slots();
            cyc(4'hF, 1'b1);
            repeat (13) cyc(4'h0, 1'b1);
            check("fair_count", 64'(grants.size()), 64'd4);
            for (int i = 0; i < 4; i++)
                if (i < grants.size()) check("fair_order", 64'(grants[i]), 64'(i));
        end

        // Backpressure with a zero message code.
        do_reset();
        set_slot(0, 8'h00, 32'h1234, 32'hBEEF);
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        repeat (BP_CYC) begin
            cyc(4'b0000, 1'b0);
            check("bp_data", 64'(bus_data), 64'hBEEF);
            check("bp_no_done", 64'(req_done), 64'd0);
        end
        cyc(4'b0000, 1'b1);
        check("bp_done", 64'(req_done), 64'b0001);
        cyc(4'b0000, 1'b1);

        // Overflow while stalled, then refill on the grant edge.
        do_reset();
        set_slot(0, 8'h10, 32'h0, 32'h0);
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        set_slot(1, 8'h11, 32'h100, 32'hAAAA);
        cyc(4'b0010, 1'b0);
        set_slot(1, 8'h12, 32'h200, 32'hBBBB);
        cyc(4'b0010, 1'b0);
        check("ovf_set", 64'(req_ovf), 64'b0010);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        set_slot(1, 8'h13, 32'h300, 32'hCCCC);
        cyc(4'b0010, 1'b1);
        check("ovf_kept_first", 64'(bus_data), 64'hAAAA);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        check("grant_edge_refill", 64'(bus_data), 64'hCCCC);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);

        // Reset asserted in the middle of a stalled transfer.
        set_slot(3, 8'h33, 32'h3, 32'h3333);
        cyc(4'b1001, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid", 64'(bus_valid), 64'd0);
        check("rst_ovf", 64'(req_ovf), 64'd0);
        check("rst_busy", 64'(is_bus_busy), 64'd0);
        check("rst_data", 64'(bus_data), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) cyc(4'b0000, 1'b1);

        // Watchdog behaviour.
        do_reset();
        cyc(4'b0001, 1'b0);
`ifdef CHAN_ARB_TIMEOUT_EN
        repeat (12) cyc(4'b0000, 1'b0);
        check("tmo_sticky", 64'(tmo_err), 64'd1);
        check("tmo_valid_low", 64'(bus_valid), 64'd0);
`else
        repeat (20) cyc(4'b0000, 1'b0);
        check("no_tmo_valid", 64'(bus_valid), 64'd1);
        check("no_tmo_err", 64'(tmo_err), 64'd0);
        repeat (3) cyc(4'b0000, 1'b1);
`endif

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] p;
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0);
            rand_slots();
            cyc(p, $urandom_range(0, 9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
